tb_sched: RTL and testbench
===========================

// Module: tb_sched
// PURPOSE
//  Traceback scheduler for the Viterbi decoder. Owns a 4-bank survivor memory
//  (ACS decision words in, traceback reads out). Generates the write bank/address
//  for incoming decisions. Sequences each traceback job: a training pass over the
//  newest full bank, then a decode pass over the previous bank. Drives the
//  traceback unit's enable/selection, aligned to memory read latency.
// PARAMETERS
//  TB_LEN  64  words per bank; power of 2, >= 4
//  RD_LAT  1   survivor-memory read latency in clocks (1..3)
// PORTS
//  clk          in   1        clock
//  rst          in   1        reset, asynchronous, active-low
//  dec_valid    in   1        ACS decision word available this cycle
//  dec_ready    out  1        scheduler accepts word (accept = valid & ready)
//  mem_we       out  4        one-hot bank write enable
//  wr_addr      out  ADDR_W   write address (ADDR_W = $clog2(TB_LEN))
//  rd_bank      out  2        bank being read
//  rd_addr      out  ADDR_W   read address
//  tbu_enable   out  1        to traceback unit, delayed RD_LAT from rd_addr
//  tbu_selection out 1        0 = training, 1 = decode; delayed RD_LAT
//  busy         out  1        job running or pending
// BEHAVIOUR
//  Reset: wr_bank=0, wr_addr=0, fill=0, FSM=IDLE, pend_v=0; mem_we=0, rd_*=0,
//   tbu_*=0, busy=0; dec_ready=1 (comb: dec_ready = !pend_v).
//  Write: mem_we[wr_bank] = dec_valid & dec_ready. wr_addr increments on accept.
//   At TB_LEN-1 it wraps to 0, wr_bank increments mod 4 (3->0), and bank k
//   completes. fill saturates at 2.
//  Job issue: on completion of bank k with fill already >=1 -> job(k):
//   train bank k, decode bank k-1 (mod 4). If IDLE, or DECODE at rd_addr 0
//   this same cycle, TRAIN starts next cycle; otherwise the job latches in
//   pend_v/pend_bank.
//  FSM IDLE -> TRAIN (job available)
//   TRAIN: rd_bank=k, rd_addr TB_LEN-1 down to 0, one per clock, sel=0.
//   TRAIN -> DECODE after addr 0. DECODE: rd_bank=k-1, addr TB_LEN-1..0, sel=1.
//   DECODE -> TRAIN if pend_v (pend_v clears) else IDLE.
//  A job takes 2*TB_LEN clocks. The tbu_enable/tbu_selection pipeline is
//   RD_LAT deep, so the tbu sees sel 1->0 between back-to-back jobs. This
//   clears its state; no idle gap is inserted.
//  Bank safety: writer stalls (dec_ready=0) while pend_v. The writer is then
//   never on a bank used by the running or pending job.
//  tbu_enable=1 exactly for cycles whose delayed rd_addr is valid. busy =
//   (FSM!=IDLE) | pend_v | enable-pipeline nonzero.
//  Reset mid-operation clears everything (jobs and fill). The first job after
//   reset needs two fresh banks.
// CONFIGURATION
//  TB_SCHED_PERF_EN defined: adds outputs stall_cnt[15:0] (clocks with
//   dec_valid & !dec_ready) and job_cnt[15:0] (completed DECODE passes).
//   Both saturate at 16'hFFFF and reset to 0.
//  Undefined: those ports and counters do not exist; no other change.
// STRUCTURE
//  Package tb_pkg: TB_LEN default, bank_t (logic [1:0]), tb_phase_e
//   {IDLE,TRAIN,DECODE}, bank_prev() function.
//  Sub-module tb_rd_engine: FSM + read down-counter + RD_LAT delay line.
//   Top holds the write side, fill, pend_v and perf counters.
// TESTING (TB_LEN=8, RD_LAT=1)
//  1 Feed 8 words: mem_we 0001, addr 0..7, no job. Feed 8 more: mem_we 0010;
//    next clk rd_bank=1 addr 7..0 sel 0, then rd_bank=0 addr 7..0 sel 1.
//    tbu_* lag rd_addr by 1 clk.
//  2 dec_valid held high 40 clks: bank 2 completes while job(1) runs; pend_v=1,
//    dec_ready=0 until job(2) TRAIN starts right after job(1) DECODE addr 0.
//    tbu_selection shows 1->0 with no enable gap.
//  3 Write 5 full banks: wr_bank wraps 3->0; job(0) trains bank 0, decodes bank 3.
//  4 Assert rst during DECODE addr 4: all outputs 0 asynchronously, dec_ready=1.
//    After release, 8 words must not start a job.
//  5 dec_valid while dec_ready=0: mem_we=0, wr_addr unchanged.
//  6 With TB_SCHED_PERF_EN, scenario 2: stall_cnt = stalled valid clocks,
//    job_cnt increments once per DECODE end.

Source files
------------

// File: rtl/tb_sched_pkg.sv
// tb_pkg: shared types and helpers for the Viterbi traceback scheduler.
package tb_pkg;
  localparam int TB_LEN_DEF = 64;
  typedef logic [1:0] bank_t;
  typedef enum logic [1:0] {IDLE, TRAIN, DECODE} tb_phase_e;
  function automatic bank_t bank_prev(input bank_t b);
    return b - 2'd1;
  endfunction
endpackage

// File: rtl/tb_sched_if.sv
// tb_sched_if: decision-write and traceback-read signals of the scheduler.
// TB_SCHED_PERF_EN adds the stall/job counters.
interface tb_sched_if import tb_pkg::*; #(parameter int ADDR_W = $clog2(TB_LEN_DEF));
  logic dec_valid;
  logic dec_ready;
  logic [3:0] mem_we;
  logic [ADDR_W-1:0] wr_addr;
  bank_t rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic tbu_enable;
  logic tbu_selection;
  logic busy;
`ifdef TB_SCHED_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] job_cnt;
  modport slave(input dec_valid, output dec_ready, mem_we, wr_addr, rd_bank, rd_addr,
                tbu_enable, tbu_selection, busy, stall_cnt, job_cnt);
  modport master(output dec_valid, input dec_ready, mem_we, wr_addr, rd_bank, rd_addr,
                 tbu_enable, tbu_selection, busy, stall_cnt, job_cnt);
`else
  modport slave(input dec_valid, output dec_ready, mem_we, wr_addr, rd_bank, rd_addr,
                tbu_enable, tbu_selection, busy);
  modport master(output dec_valid, input dec_ready, mem_we, wr_addr, rd_bank, rd_addr,
                 tbu_enable, tbu_selection, busy);
`endif
endinterface

// File: rtl/tb_sched_rd_engine.sv
// tb_rd_engine: traceback read sequencer (train pass, then decode pass) with the
// RD_LAT-deep enable/selection delay line feeding the traceback unit.
module tb_rd_engine import tb_pkg::*; #(
  parameter int TB_LEN = TB_LEN_DEF,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = $clog2(TB_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  bank_t             start_bank_i,
  output logic              can_take_o,
  output logic              dec_end_o,
  output logic              busy_o,
  output bank_t             rd_bank_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              tbu_enable_o,
  output logic              tbu_selection_o
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TB_LEN - 1);
  tb_phase_e state_q;
  bank_t bank_q;
  logic [ADDR_W-1:0] addr_q;
  logic [RD_LAT-1:0] en_q, sel_q;
  assign dec_end_o = (state_q == DECODE) && (addr_q == '0);
  assign can_take_o = (state_q == IDLE) || dec_end_o;
  assign busy_o = (state_q != IDLE) || (en_q != '0);
  assign rd_bank_o = bank_q;
  assign rd_addr_o = addr_q;
  assign tbu_enable_o = en_q[RD_LAT-1];
  assign tbu_selection_o = sel_q[RD_LAT-1];
  // A back-to-back job goes DECODE -> TRAIN directly; the sel 1->0 edge resets the tbu.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      bank_q <= '0;
      addr_q <= '0;
      en_q <= '0;
      sel_q <= '0;
    end else begin
      en_q <= RD_LAT'({en_q, state_q != IDLE});
      sel_q <= RD_LAT'({sel_q, state_q == DECODE});
      case (state_q)
        IDLE:
          if (start_i) begin
            state_q <= TRAIN;
            bank_q <= start_bank_i;
            addr_q <= LAST;
          end
        TRAIN:
          if (addr_q == '0) begin
            state_q <= DECODE;
            bank_q <= bank_prev(bank_q);
            addr_q <= LAST;
          end else addr_q <= addr_q - 1'b1;
        DECODE:
          if (addr_q != '0) addr_q <= addr_q - 1'b1;
          else if (start_i) begin
            state_q <= TRAIN;
            bank_q <= start_bank_i;
            addr_q <= LAST;
          end else begin
            state_q <= IDLE;
            bank_q <= '0;
          end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: rtl/tb_sched.sv
// tb_sched: Viterbi traceback scheduler; 4-bank survivor write side plus job issue.
// Define TB_SCHED_PERF_EN to add the saturating stall_cnt/job_cnt counters.
module tb_sched import tb_pkg::*; #(
  parameter int TB_LEN = TB_LEN_DEF,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rst,
  tb_sched_if.slave bus
);
  localparam int ADDR_W = $clog2(TB_LEN);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TB_LEN - 1);
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  bank_t wr_bank_q, wr_bank_d, pend_bank_q, pend_bank_d, start_bank;
  logic [1:0] fill_q, fill_d;
  logic pend_v_q, pend_v_d;
  logic accept, done, job_req, can_take, start, eng_busy, dec_end;
  // Writer stalls while a job is pending so it never touches a bank in use.
  assign bus.dec_ready = !pend_v_q;
  assign accept = bus.dec_valid && !pend_v_q && rst;
  assign bus.mem_we = accept ? 4'b0001 << wr_bank_q : 4'b0000;
  assign bus.wr_addr = wr_addr_q;
  assign done = accept && (wr_addr_q == LAST);
  assign job_req = done && (fill_q != 2'd0);
  assign start = (job_req || pend_v_q) && can_take;
  assign start_bank = pend_v_q ? pend_bank_q : wr_bank_q;
  assign bus.busy = eng_busy || pend_v_q;
  always_comb begin
    wr_addr_d = accept ? wr_addr_q + 1'b1 : wr_addr_q;
    wr_bank_d = done ? wr_bank_q + 2'd1 : wr_bank_q;
    fill_d = (done && fill_q != 2'd2) ? fill_q + 2'd1 : fill_q;
    pend_v_d = (job_req || pend_v_q) && !can_take;
    pend_bank_d = job_req ? wr_bank_q : pend_bank_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_addr_q <= '0;
      wr_bank_q <= '0;
      fill_q <= '0;
      pend_v_q <= 1'b0;
      pend_bank_q <= '0;
    end else begin
      wr_addr_q <= wr_addr_d;
      wr_bank_q <= wr_bank_d;
      fill_q <= fill_d;
      pend_v_q <= pend_v_d;
      pend_bank_q <= pend_bank_d;
    end
  tb_rd_engine #(.TB_LEN(TB_LEN), .RD_LAT(RD_LAT), .ADDR_W(ADDR_W)) u_eng (
    .clk(clk),
    .rst(rst),
    .start_i(start),
    .start_bank_i(start_bank),
    .can_take_o(can_take),
    .dec_end_o(dec_end),
    .busy_o(eng_busy),
    .rd_bank_o(bus.rd_bank),
    .rd_addr_o(bus.rd_addr),
    .tbu_enable_o(bus.tbu_enable),
    .tbu_selection_o(bus.tbu_selection)
  );
`ifdef TB_SCHED_PERF_EN
  logic [15:0] stall_q, stall_d, job_q, job_d;
  always_comb begin
    stall_d = (bus.dec_valid && pend_v_q && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    job_d = (dec_end && job_q != 16'hFFFF) ? job_q + 16'd1 : job_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stall_q <= '0;
      job_q <= '0;
    end else begin
      stall_q <= stall_d;
      job_q <= job_d;
    end
  assign bus.stall_cnt = stall_q;
  assign bus.job_cnt = job_q;
`endif
endmodule

// File: tb/tb_tb_sched.sv
// tb_tb_sched: directed bench for tb_sched (TB_LEN=8, RD_LAT=1) with a read-stream scoreboard.
module tb_tb_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  tb_sched_if #(.ADDR_W(3)) bus();
  tb_sched #(.TB_LEN(8), .RD_LAT(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int wb = 0;
  int widx = 0;
  int fill = 0;
  logic [5:0] exp_q[$];
  logic [1:0] prev_b = '0;
  logic [2:0] prev_a = '0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push_job(input int b);
    for (int a = 7; a >= 0; a--) exp_q.push_back({2'(b), 3'(a), 1'b0});
    for (int a = 7; a >= 0; a--) exp_q.push_back({2'((b + 3) % 4), 3'(a), 1'b1});
  endtask
  task automatic word(input logic v);
    @(negedge clk);
    bus.dec_valid = v;
    #1;
    if (v) begin
      if (bus.dec_ready) begin
        chk("mem_we", bus.mem_we, 32'(4'b0001 << wb));
        chk("wr_addr", bus.wr_addr, widx);
        widx++;
        if (widx == 8) begin
          widx = 0;
          if (fill > 0) push_job(wb);
          if (fill < 2) fill++;
          wb = (wb + 1) % 4;
        end
      end else begin
        chk("stall_mem_we", bus.mem_we, 0);
        chk("stall_wr_addr", bus.wr_addr, widx);
      end
    end
  endtask
  task automatic wait_idle();
    @(negedge clk);
    bus.dec_valid = 1'b0;
    for (int n = 0; n < 300 && bus.busy; n++) @(negedge clk);
    #1;
    chk("idle_timeout", bus.busy, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask
  always @(negedge clk) begin
    if (bus.tbu_enable) begin
      chk("stream_avail", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("stream", {prev_b, prev_a, bus.tbu_selection}, exp_q.pop_front());
    end
    prev_b = bus.rd_bank;
    prev_a = bus.rd_addr;
  end
  initial begin
    rst = 1'b0;
    bus.dec_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_rd_bank", bus.rd_bank, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_tbu_en", bus.tbu_enable, 0);
    chk("rst_tbu_sel", bus.tbu_selection, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.dec_ready, 1);
`ifdef TB_SCHED_PERF_EN
    chk("rst_stall_cnt", bus.stall_cnt, 0);
    chk("rst_job_cnt", bus.job_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    repeat (8) word(1'b1);
    for (int i = 0; i < 40; i++) begin
      word(1'b1);
      chk("dec_ready", bus.dec_ready, !((i >= 16 && i <= 23) || (i >= 32 && i <= 39)));
      if (i == 0) chk("no_first_job", bus.busy, 0);
      if (i == 8) begin
        chk("job1_rd_bank", bus.rd_bank, 1);
        chk("job1_rd_addr", bus.rd_addr, 7);
        chk("job1_tbu_lag", bus.tbu_enable, 0);
      end
      if (i >= 9) chk("tbu_enable_cont", bus.tbu_enable, 1);
      if (i == 9) chk("job1_sel_train", bus.tbu_selection, 0);
      if (i == 16) begin
        chk("job1_dec_bank", bus.rd_bank, 0);
        chk("job1_dec_addr", bus.rd_addr, 7);
      end
      if (i == 24) begin
        chk("job2_rd_bank", bus.rd_bank, 2);
        chk("job1_sel_tail", bus.tbu_selection, 1);
      end
      if (i == 25) chk("job2_sel_train", bus.tbu_selection, 0);
    end
    wait_idle();
`ifdef TB_SCHED_PERF_EN
    chk("stall_cnt", bus.stall_cnt, 16);
    chk("job_cnt", bus.job_cnt, 3);
`endif
    repeat (8) word(1'b1);
    word(1'b0);
    chk("wrap_train_bank", bus.rd_bank, 0);
    chk("wrap_train_addr", bus.rd_addr, 7);
    repeat (8) @(negedge clk);
    #1;
    chk("wrap_dec_bank", bus.rd_bank, 3);
    chk("wrap_dec_addr", bus.rd_addr, 7);
    repeat (3) @(negedge clk);
    #1;
    chk("mid_dec_addr", bus.rd_addr, 4);
    chk("mid_dec_sel", bus.tbu_selection, 1);
    rst = 1'b0;
    #1;
    chk("arst_mem_we", bus.mem_we, 0);
    chk("arst_wr_addr", bus.wr_addr, 0);
    chk("arst_rd_bank", bus.rd_bank, 0);
    chk("arst_rd_addr", bus.rd_addr, 0);
    chk("arst_tbu_en", bus.tbu_enable, 0);
    chk("arst_tbu_sel", bus.tbu_selection, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_ready", bus.dec_ready, 1);
`ifdef TB_SCHED_PERF_EN
    chk("arst_job_cnt", bus.job_cnt, 0);
`endif
    exp_q.delete();
    wb = 0;
    widx = 0;
    fill = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (8) word(1'b1);
    word(1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("post_rst_no_job", bus.busy, 0);
    chk("post_rst_tbu_en", bus.tbu_enable, 0);
    repeat (8) word(1'b1);
    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
